// File: rtl/hx8352_init_sequencer.sv
// hx8352_init_sequencer
// Walks an external init ROM (cmd/data/delay/end entries) through the HX8352
// 8080 bus controller, then streams pixels from an upstream valid/ready source,
// inserting GRAM_CMD before the first pixel of each frame.
// Optional feature: define HX8352_SEQ_LCD_RESET_EN to add the lcd_reset_n port
// and the panel reset pulse/wait that runs before the first ROM fetch.
module hx8352_init_sequencer #(
   parameter int          CLK_FREQ_HZ   = 50000000,
   parameter int          ROM_AW        = 8,
   parameter logic [15:0] GRAM_CMD      = 16'h0022,
   parameter int          RESET_LOW_MS  = 10,
   parameter int          RESET_WAIT_MS = 120
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [17:0]       rom_data,
   output logic [15:0]       bus_data,
   output logic              bus_dc,
   output logic              bus_step,
   input  logic              bus_busy,
   input  logic [15:0]       px_data,
   input  logic              px_first,
   input  logic              px_valid,
   output logic              px_ready,
   output logic              init_done
`ifdef HX8352_SEQ_LCD_RESET_EN
   ,
   output logic              lcd_reset_n
`endif
);

   // A clock slower than 1 kHz still gets a one-cycle millisecond.
   localparam int CYC_PER_MS = (CLK_FREQ_HZ / 1000 > 0) ? (CLK_FREQ_HZ / 1000) : 1;
   localparam int PW         = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CYC_PER_MS - 1);

   localparam logic [1:0] T_CMD   = 2'b00;
   localparam logic [1:0] T_DATA  = 2'b01;
   localparam logic [1:0] T_DELAY = 2'b10;
   localparam logic [1:0] T_END   = 2'b11;

   typedef enum logic [3:0] {
      S_BOOT      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_DELAY     = 4'd3,
      S_ISSUE     = 4'd4,
      S_WAIT_ACK  = 4'd5,
      S_WAIT_DONE = 4'd6,
      S_READY     = 4'd7,
      S_LCD_RST   = 4'd8,
      S_LCD_WAIT  = 4'd9
   } state_t;

   // Where a finished handshake hands control back to.
   typedef enum logic [1:0] {
      RET_INIT  = 2'd0,   // next ROM entry
      RET_PIXEL = 2'd1,   // GRAM command sent, pixel still pending
      RET_READY = 2'd2    // pixel sent, accept the next one
   } ret_t;

   state_t         state_r;
   ret_t           ret_r;
   logic [15:0]    ms_cnt_r;
   logic [PW-1:0]  pre_cnt_r;
   logic [15:0]    px_lat_r;

   logic           tick_s;
   logic           ms_done_s;
   logic [15:0]    ms_cnt_nx_s;
   logic [PW-1:0]  pre_cnt_nx_s;
   logic [1:0]     rom_type_s;
   logic [15:0]    rom_val_s;

   // Millisecond timer arithmetic shared by the delay and panel-reset states
   always_comb begin
      rom_type_s = rom_data[17:16];
      rom_val_s  = rom_data[15:0];
      tick_s     = (pre_cnt_r == PRE_LAST);
      ms_done_s  = (ms_cnt_r == 16'd0) || (tick_s && (ms_cnt_r == 16'd1));
      if (tick_s) begin
         pre_cnt_nx_s = {PW{1'b0}};
         ms_cnt_nx_s  = ms_cnt_r - 16'd1;
      end else begin
         pre_cnt_nx_s = pre_cnt_r + PW'(1);
         ms_cnt_nx_s  = ms_cnt_r;
      end
   end

   // Sequencer FSM: boot, ROM walk, ms delays, bus handshake and pixel streaming
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_BOOT;
         ret_r     <= RET_INIT;
         rom_addr  <= {ROM_AW{1'b0}};
         bus_data  <= 16'h0000;
         bus_dc    <= 1'b1;
         bus_step  <= 1'b0;
         px_ready  <= 1'b0;
         init_done <= 1'b0;
         ms_cnt_r  <= 16'd0;
         pre_cnt_r <= {PW{1'b0}};
         px_lat_r  <= 16'h0000;
`ifdef HX8352_SEQ_LCD_RESET_EN
         lcd_reset_n <= 1'b0;
`endif
      end else begin
         case (state_r)
            S_BOOT: begin
               // The controller holds busy high until it has powered up.
               if (!bus_busy) begin
                  // Preloaded for the panel reset; unused when that is absent.
                  ms_cnt_r  <= 16'(RESET_LOW_MS);
                  pre_cnt_r <= {PW{1'b0}};
`ifdef HX8352_SEQ_LCD_RESET_EN
                  state_r   <= S_LCD_RST;
`else
                  state_r   <= S_FETCH;
`endif
               end
            end

            S_LCD_RST: begin
               if (ms_done_s) begin
                  ms_cnt_r  <= 16'(RESET_WAIT_MS);
                  pre_cnt_r <= {PW{1'b0}};
`ifdef HX8352_SEQ_LCD_RESET_EN
                  lcd_reset_n <= 1'b1;
`endif
                  state_r   <= S_LCD_WAIT;
               end else begin
                  ms_cnt_r  <= ms_cnt_nx_s;
                  pre_cnt_r <= pre_cnt_nx_s;
               end
            end

            S_LCD_WAIT: begin
               if (ms_done_s) begin
                  ms_cnt_r  <= 16'd0;
                  pre_cnt_r <= {PW{1'b0}};
                  state_r   <= S_FETCH;
               end else begin
                  ms_cnt_r  <= ms_cnt_nx_s;
                  pre_cnt_r <= pre_cnt_nx_s;
               end
            end

            S_FETCH: begin
               // rom_addr is already stable; the ROM answers one cycle later.
               state_r <= S_DECODE;
            end

            S_DECODE: begin
               case (rom_type_s)
                  T_CMD: begin
                     bus_data <= rom_val_s;
                     bus_dc   <= 1'b0;
                     bus_step <= 1'b1;
                     ret_r    <= RET_INIT;
                     state_r  <= S_ISSUE;
                  end
                  T_DATA: begin
                     bus_data <= rom_val_s;
                     bus_dc   <= 1'b1;
                     bus_step <= 1'b1;
                     ret_r    <= RET_INIT;
                     state_r  <= S_ISSUE;
                  end
                  T_DELAY: begin
                     if (rom_val_s == 16'd0) begin
                        rom_addr <= rom_addr + ROM_AW'(1);
                        state_r  <= S_FETCH;
                     end else begin
                        ms_cnt_r  <= rom_val_s;
                        pre_cnt_r <= {PW{1'b0}};
                        state_r   <= S_DELAY;
                     end
                  end
                  T_END: begin
                     init_done <= 1'b1;
                     px_ready  <= 1'b1;
                     state_r   <= S_READY;
                  end
                  default: begin
                     state_r <= S_FETCH;
                  end
               endcase
            end

            S_DELAY: begin
               if (ms_done_s) begin
                  ms_cnt_r  <= 16'd0;
                  pre_cnt_r <= {PW{1'b0}};
                  rom_addr  <= rom_addr + ROM_AW'(1);
                  state_r   <= S_FETCH;
               end else begin
                  ms_cnt_r  <= ms_cnt_nx_s;
                  pre_cnt_r <= pre_cnt_nx_s;
               end
            end

            S_ISSUE: begin
               bus_step <= 1'b0;
               state_r  <= S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
               if (bus_busy) begin
                  state_r <= S_WAIT_DONE;
               end
            end

            S_WAIT_DONE: begin
               if (!bus_busy) begin
                  case (ret_r)
                     RET_INIT: begin
                        rom_addr <= rom_addr + ROM_AW'(1);
                        state_r  <= S_FETCH;
                     end
                     RET_PIXEL: begin
                        bus_data <= px_lat_r;
                        bus_dc   <= 1'b1;
                        bus_step <= 1'b1;
                        ret_r    <= RET_READY;
                        state_r  <= S_ISSUE;
                     end
                     default: begin
                        px_ready <= 1'b1;
                        state_r  <= S_READY;
                     end
                  endcase
               end
            end

            S_READY: begin
               if (px_valid && px_ready) begin
                  px_lat_r <= px_data;
                  px_ready <= 1'b0;
                  bus_step <= 1'b1;
                  state_r  <= S_ISSUE;
                  if (px_first) begin
                     bus_data <= GRAM_CMD;
                     bus_dc   <= 1'b0;
                     ret_r    <= RET_PIXEL;
                  end else begin
                     bus_data <= px_data;
                     bus_dc   <= 1'b1;
                     ret_r    <= RET_READY;
                  end
               end
            end

            default: begin
               state_r <= S_BOOT;
            end
         endcase
      end
   end

endmodule
